// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file with busy-bit scoreboard.
// Optional write-through read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;

   // Upper bounds for the write-port priority encoder; callers zero-pad unused lanes.
   localparam int MAX_WR = 8;
   localparam int MAX_AW = 16;

   typedef struct packed {
      logic       hit;
      logic [2:0] port;
   } wr_sel_t;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Highest-index enabled port whose address matches wins.
   function automatic wr_sel_t win_port(input logic [MAX_WR-1:0]        en,
                                        input logic [MAX_WR*MAX_AW-1:0] addrs,
                                        input logic [MAX_AW-1:0]        addr);
      wr_sel_t sel;
      sel = '0;
      for (int p = 0; p < MAX_WR; p++) begin
         if (en[p] && (addrs[p*MAX_AW +: MAX_AW] == addr)) begin
            sel.hit  = 1'b1;
            sel.port = 3'(p);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: a reservation sets a bit, a write to the same register clears it,
// and a reservation wins over a same-edge write.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AW       = addr_width(DEF_DEPTH),
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rsv_en,
   input  logic [AW-1:0]    rsv_addr,
   input  logic [DEPTH-1:0] clr,
   output logic [DEPTH-1:0] busy_vec,
   output logic [DEPTH-1:0] busy_next
);

   always_comb begin
      busy_next = busy_vec;
      for (int r = 0; r < DEPTH; r++) begin
         if (rsv_en && (rsv_addr == AW'(r))) begin
            busy_next[r] = 1'b1;
         end else if (clr[r]) begin
            busy_next[r] = 1'b0;
         end
      end
      if (ZERO_REG != 0) begin
         busy_next[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_vec <= '0;
      end else begin
         busy_vec <= busy_next;
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised multi-port register file with registered reads, write-port priority and a
// busy-bit scoreboard. Define REGFILE_BYPASS_EN to forward same-edge writes to the read ports.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int NUM_RD   = 2,
   parameter  int NUM_WR   = 2,
   parameter  int ZERO_REG = 1,
   localparam int AW       = addr_width(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_RD*AW-1:0]    rd_addr,
   output logic [NUM_RD*WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]       rd_busy,
   input  logic [NUM_WR-1:0]       wr_en,
   input  logic [NUM_WR*AW-1:0]    wr_addr,
   input  logic [NUM_WR*WIDTH-1:0] wr_data,
   input  logic                    rsv_en,
   input  logic [AW-1:0]           rsv_addr,
   output logic [DEPTH-1:0]        busy_vec
);

   logic [WIDTH-1:0]         mem [DEPTH];
   logic [MAX_WR-1:0]        en_pad;
   logic [MAX_WR*MAX_AW-1:0] addr_pad;
   wr_sel_t                  sel [DEPTH];
   logic [DEPTH-1:0]         wr_hit;
`ifdef REGFILE_BYPASS_EN
   logic [DEPTH-1:0]         busy_next;
`endif

   // Out-of-range and zero-register writes are masked here so every consumer sees only legal writes.
   always_comb begin
      en_pad   = '0;
      addr_pad = '0;
      for (int p = 0; p < NUM_WR; p++) begin
         addr_pad[p*MAX_AW +: MAX_AW] = MAX_AW'(wr_addr[p*AW +: AW]);
         en_pad[p] = wr_en[p]
                     && (32'(wr_addr[p*AW +: AW]) < DEPTH)
                     && !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0));
      end
   end

   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         sel[r]    = win_port(en_pad, addr_pad, MAX_AW'(r));
         wr_hit[r] = sel[r].hit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            mem[r] <= '0;
         end
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            if (sel[r].hit) begin
               mem[r] <= wr_data[int'(sel[r].port)*WIDTH +: WIDTH];
            end
         end
      end
   end

   regfile_scoreboard #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .clr       (wr_hit),
      .busy_vec  (busy_vec),
`ifdef REGFILE_BYPASS_EN
      .busy_next (busy_next)
`else
      .busy_next ()
`endif
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0]    addr;
      logic             in_range;
      logic [WIDTH-1:0] data_d;
      logic [WIDTH-1:0] data_q;
      logic             busy_d;
      logic             busy_q;
`ifdef REGFILE_BYPASS_EN
      wr_sel_t          byp;
`endif

      always_comb begin
         addr     = rd_addr[i*AW +: AW];
         in_range = (32'(addr) < DEPTH);
         data_d   = '0;
         busy_d   = 1'b0;
         if (in_range) begin
            data_d = mem[addr];
            busy_d = busy_vec[addr];
         end
`ifdef REGFILE_BYPASS_EN
         byp = win_port(en_pad, addr_pad, MAX_AW'(addr));
         if (in_range) begin
            busy_d = busy_next[addr];
         end
         if (byp.hit) begin
            data_d = wr_data[int'(byp.port)*WIDTH +: WIDTH];
         end
`endif
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_q <= '0;
            busy_q <= 1'b0;
         end else begin
            data_q <= data_d;
            busy_q <= busy_d;
         end
      end

      assign rd_data[i*WIDTH +: WIDTH] = data_q;
      assign rd_busy[i]                = busy_q;
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (default 32x32 instance plus a DEPTH=24 instance).
module tb_regfile_mp_sb;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;

   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic [31:0] busy_vec;

   logic [9:0]  rd_addr_s;
   logic [63:0] rd_data_s;
   logic [1:0]  rd_busy_s;
   logic [1:0]  wr_en_s;
   logic [9:0]  wr_addr_s;
   logic [63:0] wr_data_s;
   logic        rsv_en_s;
   logic [4:0]  rsv_addr_s;
   logic [23:0] busy_vec_s;

   int checks = 0;
   int errors = 0;

   regfile_mp_sb dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy_vec (busy_vec)
   );

   regfile_mp_sb #(.DEPTH(24)) dut24 (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr_s),
      .rd_data  (rd_data_s),
      .rd_busy  (rd_busy_s),
      .wr_en    (wr_en_s),
      .wr_addr  (wr_addr_s),
      .wr_data  (wr_data_s),
      .rsv_en   (rsv_en_s),
      .rsv_addr (rsv_addr_s),
      .busy_vec (busy_vec_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus on the 32-entry instance, then step past the next rising edge.
   task automatic applyStimulus(input logic [1:0] en,
                                input logic [4:0] a0, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [31:0] d1,
                                input logic rsv, input logic [4:0] ra,
                                input logic [4:0] r0, input logic [4:0] r1);
      wr_en    = en;
      wr_addr  = {a1, a0};
      wr_data  = {d1, d0};
      rsv_en   = rsv;
      rsv_addr = ra;
      rd_addr  = {r1, r0};
      tick();
   endtask

   initial begin
      rst = 1'b1;
      rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
      rd_addr_s = '0; wr_en_s = '0; wr_addr_s = '0; wr_data_s = '0; rsv_en_s = 1'b0; rsv_addr_s = '0;
      tick();
      tick();
      checkOutput("reset_rd_data", rd_data[31:0], 32'h0);
      checkOutput("reset_rd_busy", {30'd0, rd_busy}, 32'h0);
      checkOutput("reset_busy_vec", busy_vec, 32'h0);
      rst = 1'b0;

      // Load reg 5 and reserve reg 6, then reset asynchronously mid-cycle.
      applyStimulus(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd6);
      checkOutput("pre_reset_busy6_read", {31'd0, rd_busy[1]}, BYP ? 32'h1 : 32'h0);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
      checkOutput("pre_reset_reg5", rd_data[31:0], 32'hDEAD_BEEF);
      checkOutput("pre_reset_busy6", {31'd0, rd_busy[1]}, 32'h1);
      checkOutput("pre_reset_busy_vec", busy_vec, 32'h0000_0040);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_rd_data", rd_data[31:0], 32'h0);
      checkOutput("async_rst_rd_busy", {30'd0, rd_busy}, 32'h0);
      checkOutput("async_rst_busy_vec", busy_vec, 32'h0);
      #2 rst = 1'b0;
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
      checkOutput("post_rst_reg5", rd_data[31:0], 32'h0);

      // Basic write then read on the other port.
      applyStimulus(2'b01, 5'd3, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3);
      checkOutput("basic_reg3_port1", rd_data[63:32], 32'h1234);

      // Same-edge read/write of reg 7.
      applyStimulus(2'b01, 5'd7, 32'h1111, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      applyStimulus(2'b01, 5'd7, 32'hA5A5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3);
      checkOutput("same_edge_reg7", rd_data[31:0], BYP ? 32'hA5A5 : 32'h1111);
      checkOutput("indep_reg3", rd_data[63:32], 32'h1234);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
      checkOutput("after_reg7", rd_data[31:0], 32'hA5A5);

      // Write collision on reg 9: port 1 must win.
      applyStimulus(2'b11, 5'd9, 32'h1, 5'd9, 32'h2, 1'b0, 5'd0, 5'd0, 5'd9);
      checkOutput("collision_same_edge", rd_data[63:32], BYP ? 32'h2 : 32'h0);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
      checkOutput("collision_reg9", rd_data[31:0], 32'h2);

      // Zero register: write and reserve are dropped.
      applyStimulus(2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
      checkOutput("zero_same_edge", rd_data[31:0], 32'h0);
      checkOutput("zero_busy_vec", busy_vec, 32'h0);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("zero_read", rd_data[31:0], 32'h0);
      checkOutput("zero_rd_busy", {31'd0, rd_busy[0]}, 32'h0);

      // Scoreboard set, clear and reserve-beats-write.
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd4);
      checkOutput("sb_reserve4", busy_vec, 32'h0000_0010);
      applyStimulus(2'b10, 5'd0, 32'h0, 5'd4, 32'h44, 1'b0, 5'd0, 5'd0, 5'd4);
      checkOutput("sb_clear4", busy_vec, 32'h0);
      checkOutput("sb_rd_busy4", {31'd0, rd_busy[1]}, BYP ? 32'h0 : 32'h1);
      applyStimulus(2'b01, 5'd4, 32'h55, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd4);
      checkOutput("sb_rsv_beats_wr", busy_vec, 32'h0000_0010);
      applyStimulus(2'b10, 5'd0, 32'h0, 5'd4, 32'h66, 1'b0, 5'd0, 5'd4, 5'd4);
      checkOutput("sb_reg4_data", rd_data[31:0], BYP ? 32'h66 : 32'h55);
      checkOutput("sb_final_clear", busy_vec, 32'h0);

      // DEPTH=24 instance: address 30 is out of range for write, reserve and read.
      wr_en_s = 2'b01; wr_addr_s = {5'd0, 5'd30}; wr_data_s = {32'h0, 32'h0000_0BAD};
      rsv_en_s = 1'b1; rsv_addr_s = 5'd30; rd_addr_s = {5'd14, 5'd30};
      tick();
      checkOutput("oor_busy_vec", {8'd0, busy_vec_s}, 32'h0);
      wr_en_s = 2'b10; wr_addr_s = {5'd23, 5'd0}; wr_data_s = {32'h23, 32'h0};
      rsv_en_s = 1'b0; rsv_addr_s = 5'd0;
      tick();
      wr_en_s = 2'b00; rd_addr_s = {5'd23, 5'd30};
      tick();
      checkOutput("oor_read30", rd_data_s[31:0], 32'h0);
      checkOutput("oor_busy30", {31'd0, rd_busy_s[0]}, 32'h0);
      checkOutput("d24_reg23", rd_data_s[63:32], 32'h23);
      rd_addr_s = {5'd14, 5'd6};
      tick();
      checkOutput("oor_no_alias6", rd_data_s[31:0], 32'h0);
      checkOutput("oor_no_alias14", rd_data_s[63:32], 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the MIPS datapath, successor to the single-write, dual-read file.
- Configurable width, depth, read-port count and write-port count; synchronous registered reads; hardwired zero register; multi-write priority.
- Adds a busy-bit scoreboard: issue logic reserves a destination, and the matching write clears it.
- Sits between decode (read/reserve) and writeback (write).

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (≥2); AW = $clog2(DEPTH) is a derived localparam
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports (≥1)
- ZERO_REG, 1, when 1: register 0 reads 0, is never written and is never busy

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  registered read data, port i at [i*WIDTH +: WIDTH]
- rd_busy  out  NUM_RD  registered busy flag of the addressed register
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  packed write addresses
- wr_data  in  NUM_WR*WIDTH  packed write data
- rsv_en  in  1  reserve (mark busy) request
- rsv_addr  in  AW  register to reserve
- busy_vec  out  DEPTH  current scoreboard state, for debug and hazard logic

Behaviour:
- Reset (async, immediate on rst high): all registers = 0, all busy bits = 0, rd_data = 0, rd_busy = 0. Reset asserted mid-write discards that write.
- Read latency is 1 cycle: rd_data[i] / rd_busy[i] update at edge N with the array and scoreboard contents at edge N, for rd_addr[i] sampled at edge N.
  - Without bypass, a same-edge write is NOT visible; the old value is returned.
- Write: at each edge, every port with wr_en=1 and an in-range address updates the array.
  - Same address on multiple ports: the highest-index port wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Out-of-range address (≥DEPTH, only possible when DEPTH is not a power of two):
  - read returns 0 with busy 0;
  - write and reserve are ignored.
- Scoreboard, per register r, at each edge:
  - set if rsv_en and rsv_addr==r;
  - else clear if any wr_en port targets r;
  - else hold.
  - Reservation beats a same-edge write (new producer issued).
  - ZERO_REG=1: busy[0] is constant 0.
- busy_vec is the scoreboard register itself (no extra latency).
- Simultaneous read and write to different addresses are independent. No structural stalls exist; the block never backpressures.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding on the read side.
  - If any write port targets rd_addr[i] at edge N, rd_data[i] captures that write's data (highest-index port wins).
  - rd_busy[i] uses the next-state busy bit.
  - ZERO_REG and range rules still apply.
- Undefined: reads see pre-edge state only, as above.

Decomposition:
- Package regfile_pkg:
  - default WIDTH/DEPTH constants;
  - a function computing the winning write port for an address (priority encode);
  - a localparam/function for AW.
- One sub-module, regfile_scoreboard: holds the busy bits and the set/clear/priority logic, outputs busy_vec and next-state busy.
- The main module holds the array, write arbitration, read registers and optional bypass.

Test Plan:
- Reset: pulse rst mid-cycle after loading reg 5 = 0xDEAD_BEEF → rd_data and rd_busy go 0 immediately; reading reg 5 after release gives 0.
- Basic write/read: write reg 3 = 0x1234 via port 0; next edge read port 1 addr 3 → rd_data1 = 0x1234 one cycle after the address is applied.
- Same-edge read/write of reg 7 = 0xA5A5 (old value 0x1111) → 0x1111 without REGFILE_BYPASS_EN, 0xA5A5 with it.
- Write collision: port 0 writes reg 9 = 0x1, port 1 writes reg 9 = 0x2 on the same edge → reg 9 reads 0x2.
- Zero register (ZERO_REG=1): write reg 0 = 0xFFFF_FFFF and reserve reg 0 → reads 0, busy_vec[0] = 0.
- Scoreboard: reserve reg 4 → busy_vec[4] = 1; write reg 4 → clears to 0. Reserve and write reg 4 on the same edge → busy_vec[4] stays 1. With DEPTH=24, writing addr 30 is ignored and reading it returns 0.
